// File: rtl/divide_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : divide_pkg
//  Purpose  : Shared widths, FSM state type, result record and the
//             quotient-saturation helper for the sequential divider.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package divide_pkg;

  localparam int DVD_W = 5;          // dividend width
  localparam int DVR_W = 2;          // divisor width
  localparam int QUO_W = 3;          // output quotient width
  localparam int STEPS = 5;          // one quotient bit per dividend bit
  localparam int REM_W = 3;          // internal partial-remainder width
  localparam int CNT_W = 3;          // step counter width (0..STEPS-1)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [QUO_W-1:0] q;
    logic [DVR_W-1:0] r;
    logic             ovf;
    logic             dz;
  } result_t;

  // Saturate the full-width quotient into the narrow output field.
  function automatic result_t make_result(input logic [DVD_W-1:0] quo,
                                          input logic [REM_W-1:0] rem);
    result_t res;
    res.ovf = |quo[DVD_W-1:QUO_W];
    res.q   = res.ovf ? {QUO_W{1'b1}} : quo[QUO_W-1:0];
    res.r   = DVR_W'(rem);
    res.dz  = 1'b0;
    return res;
  endfunction

endpackage : divide_pkg
`default_nettype wire

// File: rtl/divide_if.sv
`default_nettype none
// ============================================================================
//  Module   : divide_if
//  Purpose  : Request/result bundle of the divider.
//  Signals  : start, p[4:0], y[1:0]          requester -> divider
//             ready, valid, q[2:0], r[1:0],
//             ovf, dz                        divider -> requester
//  Modports : master (requester), slave (divider)
//  Revision : 1.0  initial release
// ============================================================================
interface divide_if;
  import divide_pkg::*;

  logic             start;
  logic [DVD_W-1:0] p;
  logic [DVR_W-1:0] y;
  logic             ready;
  logic             valid;
  logic [QUO_W-1:0] q;
  logic [DVR_W-1:0] r;
  logic             ovf;
  logic             dz;

  modport master (
    output start, p, y,
    input  ready, valid, q, r, ovf, dz
  );

  modport slave (
    input  start, p, y,
    output ready, valid, q, r, ovf, dz
  );

endinterface : divide_if
`default_nettype wire

// File: rtl/divide_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational restoring-division step: shift the next
//             dividend bit into the partial remainder, subtract the divisor
//             when it fits and report the resulting quotient bit.
//  Ports    : i_rem_in  [2:0]  partial remainder before the step
//             i_bit_in         next dividend bit (MSB first)
//             i_divisor [1:0]  divisor (non-zero)
//             o_rem_out [2:0]  partial remainder after the step
//             o_q_bit          quotient bit produced by the step
//  Revision : 1.0  initial release
// ============================================================================
module div_step
  import divide_pkg::*;
(
  input  logic [REM_W-1:0] i_rem_in,
  input  logic             i_bit_in,
  input  logic [DVR_W-1:0] i_divisor,
  output logic [REM_W-1:0] o_rem_out,
  output logic             o_q_bit
);

  // One bit wider than the remainder so the shifted value never wraps.
  logic [REM_W:0] w_shift;
  logic [REM_W:0] w_dvr;

  assign w_shift   = {i_rem_in, i_bit_in};
  assign w_dvr     = (REM_W+1)'(i_divisor);
  assign o_q_bit   = (w_shift >= w_dvr);
  // Remainder stays below the divisor, so the narrowing never loses bits.
  assign o_rem_out = REM_W'(o_q_bit ? (w_shift - w_dvr) : w_shift);

endmodule : div_step
`default_nettype wire

// File: rtl/divide.sv
`default_nettype none
// ============================================================================
//  Module   : divide
//  Purpose  : Sequential 5-bit / 2-bit unsigned restoring divider with a
//             saturating 3-bit quotient, overflow and divide-by-zero flags.
//  Ports    : clk    rising-edge clock
//             rst_n  synchronous active-low reset
//             bus    divide_if.slave: start/p/y in; ready/valid/q/r/ovf/dz out
//  Revision : 1.0  initial release
// ============================================================================
module divide
  import divide_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  divide_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(STEPS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DVD_W-1:0]   r_dvd;        // dividend, shifted left each step
  logic [DVR_W-1:0]   r_dvr;
  logic [REM_W-1:0]   r_rem;
  logic [DVD_W-2:0]   r_quo;        // quotient bits gathered before the last step
  logic [CNT_W-1:0]   r_cnt;
  result_t            r_res;

  logic [REM_W-1:0]   w_rem_nxt;
  logic               w_q_bit;
  logic [DVD_W-1:0]   w_quo_nxt;
  logic               w_last;

  div_step u_step (
    .i_rem_in  (r_rem),
    .i_bit_in  (r_dvd[DVD_W-1]),
    .i_divisor (r_dvr),
    .o_rem_out (w_rem_nxt),
    .o_q_bit   (w_q_bit)
  );

  assign w_quo_nxt = {r_quo, w_q_bit};
  assign w_last    = (r_cnt == c_last);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          // A zero divisor skips the arithmetic entirely.
          w_state_nxt = (bus.y == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dvd <= '0;
      r_dvr <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_res <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.y == '0) begin
              r_res.q   <= '0;
              r_res.r   <= '0;
              r_res.ovf <= 1'b0;
              r_res.dz  <= 1'b1;
            end else begin
              r_dvd <= bus.p;
              r_dvr <= bus.y;
              r_rem <= '0;
              r_quo <= '0;
              r_cnt <= '0;
            end
          end
        end
        ST_CALC: begin
          r_dvd <= {r_dvd[DVD_W-2:0], 1'b0};
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt[DVD_W-2:0];
          r_cnt <= r_cnt + CNT_W'(1);
          // Results change only on the edge that enters DONE.
          if (w_last) begin
            r_res <= make_result(w_quo_nxt, w_rem_nxt);
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs come straight from registers.
  assign bus.ready = (r_state == ST_IDLE);
  assign bus.valid = (r_state == ST_DONE);
  assign bus.q     = r_res.q;
  assign bus.r     = r_res.r;
  assign bus.ovf   = r_res.ovf;
  assign bus.dz    = r_res.dz;

endmodule : divide
`default_nettype wire

// File: doc/divide.md
DIVIDE -- requirements
Module: divide

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 Port: start  input  1  request a division; accepted only when ready=1.
REQ-005 Port: p  input  5  dividend (product-width operand, unsigned).
REQ-006 Port: y  input  2  divisor (unsigned).
REQ-007 Port: ready  output  1  high in IDLE only.
REQ-008 Port: valid  output  1  one-cycle pulse marking a completed result.
REQ-009 Port: q  output  3  quotient (unsigned, saturating).
REQ-010 Port: r  output  2  remainder (unsigned).
REQ-011 Port: ovf  output  1  true quotient exceeded 7.
REQ-012 Port: dz  output  1  divisor was zero.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE; all transitions on rising clk.
REQ-014 IDLE: start=1 with y!=0 SHALL capture p, y, clear partial remainder and counter, and go to CALC.
REQ-015 IDLE: start=1 with y=0 SHALL go directly to DONE with dz=1, q=0, r=0, ovf=0.
REQ-016 CALC: restoring division, one quotient bit per cycle, MSB first, over exactly 5 cycles (count 0..4).
REQ-017 Each step: rem = {rem, next dividend bit}; if rem >= divisor, subtract and shift in 1, else shift in 0; rem width 3 bits internal.
REQ-018 After the 5th CALC cycle, state SHALL go to DONE.
REQ-019 Latency: start accepted at edge N -> valid=1 during the cycle after edge N+6 (DONE); dz path: valid after edge N+1.
REQ-020 DONE: valid=1 for exactly one cycle, then IDLE unconditionally.
REQ-021 5-bit quotient > 7: q=7, ovf=1, r=true remainder; else q=quotient[2:0], ovf=0.
REQ-022 q, r, ovf, dz SHALL be updated only on entry to DONE and held stable until the next DONE.
REQ-023 start while ready=0 SHALL be ignored; no queuing.
REQ-024 p and y changes after acceptance SHALL NOT affect the result.
REQ-025 start high in the cycle that DONE returns to IDLE SHALL be accepted on the following edge (ready=1 in IDLE).
REQ-026 For all x in 0..7, y in 1..3: dividing p=x*y by y SHALL return q=x, r=0, ovf=0.

Reset
REQ-027 rst_n=0 at an edge SHALL force IDLE, ready=1, valid=0, q=0, r=0, ovf=0, dz=0, clear counter and operand registers.
REQ-028 Reset mid-CALC SHALL abandon the operation with no valid pulse.
REQ-029 Reset SHALL take priority over start.

Structure
REQ-030 Shared package divide_pkg SHALL hold dividend width (5), divisor width (2), quotient width (3), step count (5) and the state enum.
REQ-031 One combinational sub-module div_step SHALL implement a single restoring step (rem_in, bit_in, divisor -> rem_out, q_bit).
REQ-032 Implementation SHALL have no combinational path from inputs to outputs.

Verification
REQ-033 p=6, y=2, start at edge N -> valid after edge N+6, q=3, r=0, ovf=0, dz=0.
REQ-034 p=31, y=3 -> q=7, r=1, ovf=1; p=21, y=3 -> q=7, r=0, ovf=0.
REQ-035 p=5, y=0 -> valid after edge N+1, dz=1, q=0, r=0; next start with y=1 clears dz.
REQ-036 start pulses during CALC with other operands -> ignored, result matches first operands.
REQ-037 rst_n=0 at 3rd CALC cycle -> no valid, all outputs 0, ready=1 next cycle.
REQ-038 Exhaustive loop x=0..7, y=1..3 with back-to-back starts -> q=x, r=0 for p=x*y.
